// File: rtl/regfile_multiport.sv
// NREGS x XLEN register file: NREAD combinational read ports, one synchronous write port,
// x0 hardwired to zero, post-reset clear sweep. Define REGFILE_BYPASS_EN for write-through forwarding.
module regfile_multiport #(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned NREGS = 32,
  parameter  int unsigned NREAD = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RUWr,
  input  logic [AW-1:0]         Rd,
  input  logic [XLEN-1:0]       DataWr,
  input  logic [NREAD*AW-1:0]   Rs,
  output logic [NREAD*XLEN-1:0] RURs,
  output logic                  busy
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] mem_q [NREGS];
  logic            clr_we_c;
  logic            wr_en_c;

  // State and sweep counter; reset restarts the sweep at x1 (x0 is never stored)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: sweep one register per edge, then accept writes
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    clr_we_c = 1'b0;
    wr_en_c  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we_c = 1'b1;
        if (idx_q == AW'(NREGS - 1)) begin
          state_d = READY;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      READY: begin
        wr_en_c = RUWr && (Rd != '0);
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Storage; no writes land on a reset edge, user writes are dropped during the sweep
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we_c) begin
        mem_q[idx_q] <= '0;
      end else if (wr_en_c) begin
        mem_q[Rd] <= DataWr;
      end
    end
  end

  assign busy = rst || (state_q == CLEAR);

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0]   ra_c;
    logic [XLEN-1:0] rdata_c;

    assign ra_c = Rs[g*AW +: AW];

    // x0 and busy reads return zero, which also masks any X left in unswept storage
    always_comb begin
      rdata_c = '0;
      if (!busy && (ra_c != '0)) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_en_c && (ra_c == Rd)) begin
          rdata_c = DataWr;
        end else begin
          rdata_c = mem_q[ra_c];
        end
`else
        rdata_c = mem_q[ra_c];
`endif
      end
    end

    assign RURs[g*XLEN +: XLEN] = rdata_c;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport (NREAD=3); honours REGFILE_BYPASS_EN when defined.
module tb_regfile_multiport;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NREAD = 3;
  localparam int unsigned AW    = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string           tag;
    int              port;
    logic [XLEN-1:0] val;
  } sb_t;

  logic                  clk;
  logic                  rst;
  logic                  ruwr;
  logic [AW-1:0]         rd;
  logic [XLEN-1:0]       data_wr;
  logic [NREAD*AW-1:0]   rs;
  logic [NREAD*XLEN-1:0] rurs;
  logic                  busy;

  logic [XLEN-1:0] mdl [NREGS];
  sb_t             sb_q [$];
  int              n_tests;
  int              n_fail;

  regfile_multiport #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NREAD (NREAD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .RUWr   (ruwr),
    .Rd     (rd),
    .DataWr (data_wr),
    .Rs     (rs),
    .RURs   (rurs),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge, outputs are sampled 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rs(input int a0, input int a1, input int a2);
    rs = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic push_exp(input string tag, input int port, input logic [XLEN-1:0] val);
    sb_q.push_back('{tag, port, val});
  endtask

  task automatic drain_sb();
    sb_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, rurs[e.port*XLEN +: XLEN], e.val);
    end
  endtask

  task automatic wr(input int a, input logic [XLEN-1:0] d);
    ruwr = 1'b1;
    rd = AW'(a);
    data_wr = d;
    tick();
    ruwr = 1'b0;
    if (a != 0) mdl[a] = d;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
  endtask

  task automatic preload();
    for (int i = 1; i < NREGS; i++) wr(i, 32'h1000_0000 | XLEN'(i));
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < NREGS; i += 3) begin
      set_rs(i, (i + 1) % NREGS, (i + 2) % NREGS);
      for (int p = 0; p < 3; p++) push_exp(tag, p, mdl[(i + p) % NREGS]);
      drain_sb();
    end
  endtask

  initial begin
    int n;
    int m;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    ruwr = 1'b0;
    rd = '0;
    data_wr = '0;
    rs = '0;
    clear_model();

    tick();
    tick();
    chk("busy_in_rst", XLEN'(busy), 32'd1);
    set_rs(1, 2, 0);
    push_exp("rd_in_rst", 0, '0);
    push_exp("rd_in_rst", 2, '0);
    drain_sb();

    rst = 1'b0;
    wait_ready(n);
    chk("first_sweep_len", XLEN'(n), 32'd31);
    chk("busy_after_sweep", XLEN'(busy), 32'd0);
    read_all("zero_after_first_sweep");

    preload();
    read_all("preload");
    rst = 1'b1;
    #1;
    chk("busy_rst_comb", XLEN'(busy), 32'd1);
    tick();
    rst = 1'b0;
    wait_ready(n);
    chk("sweep_len", XLEN'(n), 32'd31);
    clear_model();
    read_all("zero_after_sweep");

    // Writes attempted during the sweep are dropped
    preload();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    repeat (5) begin
      tick();
      n++;
    end
    ruwr = 1'b1;
    rd = AW'(31);
    data_wr = 32'hA5A5A5A5;
    tick();
    n++;
    rd = AW'(2);
    data_wr = 32'h5A5A5A5A;
    tick();
    n++;
    ruwr = 1'b0;
    wait_ready(m);
    chk("sweep_len_with_wr", XLEN'(n + m), 32'd31);
    clear_model();
    set_rs(31, 2, 1);
    push_exp("clear_wr_x31", 0, '0);
    push_exp("clear_wr_x2", 1, '0);
    push_exp("clear_wr_x1", 2, '0);
    drain_sb();

    // Reset mid-sweep restarts the full sweep
    preload();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("busy_mid_sweep", XLEN'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(n);
    chk("restart_sweep_len", XLEN'(n), 32'd31);
    clear_model();
    read_all("zero_after_restart");

    wr(5, 32'hDEADBEEF);
    wr(7, 32'h12345678);
    set_rs(5, 5, 7);
    push_exp("basic_p0", 0, 32'hDEADBEEF);
    push_exp("basic_p1", 1, 32'hDEADBEEF);
    push_exp("basic_p2", 2, 32'h12345678);
    drain_sb();

    ruwr = 1'b1;
    rd = '0;
    data_wr = 32'hFFFFFFFF;
    set_rs(0, 0, 5);
    push_exp("x0_wr_cycle", 0, '0);
    push_exp("x0_wr_cycle_p1", 1, '0);
    drain_sb();
    tick();
    ruwr = 1'b0;
    push_exp("x0_after_wr", 0, '0);
    push_exp("x0_neighbour", 2, 32'hDEADBEEF);
    drain_sb();

    wr(3, 32'h1);
    ruwr = 1'b1;
    rd = AW'(3);
    data_wr = 32'hCAFEF00D;
    set_rs(3, 3, 7);
    push_exp("hazard_pre_p0", 0, BYP ? 32'hCAFEF00D : 32'h1);
    push_exp("hazard_pre_p1", 1, BYP ? 32'hCAFEF00D : 32'h1);
    push_exp("hazard_other", 2, 32'h12345678);
    drain_sb();
    tick();
    ruwr = 1'b0;
    mdl[3] = 32'hCAFEF00D;
    push_exp("hazard_post", 0, 32'hCAFEF00D);
    drain_sb();

    // Random traffic against the reference model
    for (int c = 0; c < 60; c++) begin
      int a [3];
      logic we;
      int wa;
      logic [XLEN-1:0] wd;
      logic [XLEN-1:0] ev;
      we = 1'($urandom_range(0, 1));
      wa = int'($urandom_range(0, NREGS - 1));
      wd = XLEN'($urandom);
      for (int p = 0; p < 3; p++) begin
        a[p] = (p == 0 && c % 3 == 0) ? wa : int'($urandom_range(0, NREGS - 1));
      end
      ruwr = we;
      rd = AW'(wa);
      data_wr = wd;
      set_rs(a[0], a[1], a[2]);
      for (int p = 0; p < 3; p++) begin
        if (a[p] == 0) ev = '0;
        else if (BYP && we && wa != 0 && a[p] == wa) ev = wd;
        else ev = mdl[a[p]];
        push_exp("rand", p, ev);
      end
      drain_sb();
      tick();
      if (we && wa != 0) mdl[wa] = wd;
    end
    ruwr = 1'b0;
    read_all("final_readback");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
